// File: rtl/mem_srv_pkg.sv
// Shared types and constants for the cache-line memory server.
// Both the top level and the round-robin arbiter import this package.
package mem_srv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LAT,
      RD_BURST,
      WR_BURST,
      ERR
   } srv_state_t;

   typedef enum logic {
      SRC_I = 1'b0,
      SRC_D = 1'b1
   } src_t;

   localparam int DEF_LINE_WORDS = 16;
   localparam int LINE_OFS_BITS  = $clog2(DEF_LINE_WORDS) + 2;

endpackage

// File: rtl/mem_srv_arb.sv
// Two-way round-robin arbiter between the I-cache and D-cache request ports.
// A lone requester wins at once; on a tie the side not granted last wins.
module mem_srv_arb
   import mem_srv_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_vld,
   input  logic d_vld,
   input  logic adv,
   output src_t grant
);

   src_t prio_reg;
   src_t prio_next;

   always_comb begin
      grant     = prio_reg;
      prio_next = prio_reg;
      if (i_vld && !d_vld) begin
         grant = SRC_I;
      end else if (d_vld && !i_vld) begin
         grant = SRC_D;
      end
      if (adv) begin
         prio_next = (grant == SRC_I) ? SRC_D : SRC_I;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio_reg <= SRC_D;
      end else begin
         prio_reg <= prio_next;
      end
   end

endmodule

// File: rtl/mem_line_server.sv
// Memory-side responder: serves whole-line fills to both caches and absorbs
// D-cache writebacks, one line at a time, from a word-addressed backing array.
module mem_line_server
   import mem_srv_pkg::*;
#(
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   parameter int MEM_LINES  = 256,
   parameter int RD_LAT     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req_vld,
   input  logic [31:0] i_req_addr,
   output logic        i_req_rdy,
   output logic        i_rsp_vld,
   output logic [31:0] i_rsp_data,
   output logic        i_rsp_last,
   output logic        i_rsp_err,
   input  logic        d_req_vld,
   input  logic        d_req_wr,
   input  logic [31:0] d_req_addr,
   output logic        d_req_rdy,
   input  logic        d_wvld,
   input  logic [31:0] d_wdata,
   output logic        d_rsp_vld,
   output logic [31:0] d_rsp_data,
   output logic        d_rsp_last,
   output logic        d_wr_done,
   output logic        d_rsp_err
);

   localparam int OFS_BITS = $clog2(LINE_WORDS) + 2;
   localparam int IDX_W    = 32 - OFS_BITS;
   localparam int BEAT_W   = $clog2(LINE_WORDS);
   localparam int LINE_W   = $clog2(MEM_LINES);
   localparam int MADDR_W  = LINE_W + BEAT_W;
   localparam int LAT_W    = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

   srv_state_t          state_reg, state_next;
   src_t                src_reg, src_next;
   logic [LINE_W-1:0]   line_reg, line_next;
   logic [BEAT_W-1:0]   beat_reg, beat_next;
   logic [LAT_W-1:0]    lat_reg, lat_next;
   logic                done_reg, done_next;

   src_t                grant;
   logic                accept;
   logic [IDX_W-1:0]    req_idx;
   logic                req_wr;
   logic [BEAT_W-1:0]   beat_inc;
   logic                mem_we;
   logic                mem_re;
   logic [MADDR_W-1:0]  mem_raddr;
   logic [31:0]         rd_q_reg;
   logic [31:0]         mem [MEM_LINES*LINE_WORDS];
   logic [1:0]          side_vld;
   logic [1:0]          side_err;
   logic                unused_addr_bits;

   // rst gates accept so rdy reads 0 for as long as reset is held
   assign accept = (state_reg == IDLE) && (i_req_vld || d_req_vld) && !rst;

   mem_srv_arb u_arb (
      .clk   (clk),
      .rst   (rst),
      .i_vld (i_req_vld),
      .d_vld (d_req_vld),
      .adv   (accept),
      .grant (grant)
   );

   assign req_idx  = (grant == SRC_I) ? i_req_addr[31:OFS_BITS] : d_req_addr[31:OFS_BITS];
   assign req_wr   = (grant == SRC_D) && d_req_wr;
   assign beat_inc = beat_reg + 1'b1;

   assign unused_addr_bits = ^{i_req_addr[OFS_BITS-1:0], d_req_addr[OFS_BITS-1:0]};

   always_comb begin
      state_next = state_reg;
      src_next   = src_reg;
      line_next  = line_reg;
      beat_next  = beat_reg;
      lat_next   = lat_reg;
      done_next  = 1'b0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      mem_raddr  = {line_reg, beat_inc};
      case (state_reg)
         IDLE: begin
            if (accept) begin
               src_next  = grant;
               line_next = req_idx[LINE_W-1:0];
               beat_next = '0;
               lat_next  = '0;
               if (req_idx >= IDX_W'(MEM_LINES)) begin
                  state_next = ERR;
               end else if (req_wr) begin
                  state_next = WR_BURST;
               end else begin
                  state_next = LAT;
               end
            end
         end
         LAT: begin
            if (lat_reg == LAT_W'(RD_LAT - 2)) begin
               mem_re     = 1'b1;
               mem_raddr  = {line_reg, {BEAT_W{1'b0}}};
               state_next = RD_BURST;
            end else begin
               lat_next = lat_reg + 1'b1;
            end
         end
         RD_BURST: begin
            // the array is read one beat ahead of the word being presented
            beat_next = beat_inc;
            mem_re    = (beat_reg != LAST_BEAT);
            if (beat_reg == LAST_BEAT) begin
               state_next = IDLE;
            end
         end
         WR_BURST: begin
            if (d_wvld) begin
               mem_we    = 1'b1;
               beat_next = beat_inc;
               if (beat_reg == LAST_BEAT) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end
            end
         end
         ERR: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         src_reg   <= SRC_D;
         line_reg  <= '0;
         beat_reg  <= '0;
         lat_reg   <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         src_reg   <= src_next;
         line_reg  <= line_next;
         beat_reg  <= beat_next;
         lat_reg   <= lat_next;
         done_reg  <= done_next;
      end
   end

   // Backing store: no reset so contents survive rst and map to block RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[{line_reg, beat_reg}] <= d_wdata;
      end
      if (mem_re) begin
         rd_q_reg <= mem[mem_raddr];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_side
         assign side_vld[gi] = (state_reg == RD_BURST) && (src_reg == ((gi == 0) ? SRC_I : SRC_D));
         assign side_err[gi] = (state_reg == ERR) && (src_reg == ((gi == 0) ? SRC_I : SRC_D));
      end
   endgenerate

   assign i_req_rdy  = accept && (grant == SRC_I) && i_req_vld;
   assign d_req_rdy  = accept && (grant == SRC_D) && d_req_vld;

   assign i_rsp_vld  = side_vld[0];
   assign i_rsp_data = side_vld[0] ? rd_q_reg : 32'h0;
   assign i_rsp_last = side_vld[0] && (beat_reg == LAST_BEAT);
   assign i_rsp_err  = side_err[0];

   assign d_rsp_vld  = side_vld[1];
   assign d_rsp_data = side_vld[1] ? rd_q_reg : 32'h0;
   assign d_rsp_last = side_vld[1] && (beat_reg == LAST_BEAT);
   assign d_rsp_err  = side_err[1];
   assign d_wr_done  = done_reg;

endmodule

// File: tb/tb_mem_line_server.sv
// Directed self-checking bench for mem_line_server: writeback/fill round trips,
// stalls, arbitration, range errors, reset mid-burst and busy hold-off.
module tb_mem_line_server;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req_vld = 1'b0;
   logic [31:0] i_req_addr = '0;
   logic        i_req_rdy;
   logic        i_rsp_vld;
   logic [31:0] i_rsp_data;
   logic        i_rsp_last;
   logic        i_rsp_err;
   logic        d_req_vld = 1'b0;
   logic        d_req_wr = 1'b0;
   logic [31:0] d_req_addr = '0;
   logic        d_req_rdy;
   logic        d_wvld = 1'b0;
   logic [31:0] d_wdata = '0;
   logic        d_rsp_vld;
   logic [31:0] d_rsp_data;
   logic        d_rsp_last;
   logic        d_wr_done;
   logic        d_rsp_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_line_server dut (
      .clk        (clk),
      .rst        (rst),
      .i_req_vld  (i_req_vld),
      .i_req_addr (i_req_addr),
      .i_req_rdy  (i_req_rdy),
      .i_rsp_vld  (i_rsp_vld),
      .i_rsp_data (i_rsp_data),
      .i_rsp_last (i_rsp_last),
      .i_rsp_err  (i_rsp_err),
      .d_req_vld  (d_req_vld),
      .d_req_wr   (d_req_wr),
      .d_req_addr (d_req_addr),
      .d_req_rdy  (d_req_rdy),
      .d_wvld     (d_wvld),
      .d_wdata    (d_wdata),
      .d_rsp_vld  (d_rsp_vld),
      .d_rsp_data (d_rsp_data),
      .d_rsp_last (d_rsp_last),
      .d_wr_done  (d_wr_done),
      .d_rsp_err  (d_rsp_err)
   );

   function automatic logic [72:0] all_outs();
      return {i_req_rdy, i_rsp_vld, i_rsp_data, i_rsp_last, i_rsp_err,
              d_req_rdy, d_rsp_vld, d_rsp_data, d_rsp_last, d_wr_done, d_rsp_err};
   endfunction

   // Holds a request until rdy, then drops it just after the accept edge.
   task automatic req_accept(input bit is_d, input bit wr, input logic [31:0] addr, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         if (is_d) begin
            d_req_vld = 1'b1; d_req_wr = wr; d_req_addr = addr;
         end else begin
            i_req_vld = 1'b1; i_req_addr = addr;
         end
         #1;
         ok = is_d ? d_req_rdy : i_req_rdy;
      end
      @(posedge clk); #1;
      if (is_d) d_req_vld = 1'b0; else i_req_vld = 1'b0;
   endtask

   task automatic run_fill(input bit is_d, input logic [31:0] addr, output bit ok, output int lat,
                           output int nbeats, output logic [31:0] words [16], output int last_at,
                           output bit stray);
      lat = -1; nbeats = 0; last_at = -1; stray = 1'b0;
      for (int k = 0; k < 16; k++) words[k] = '0;
      req_accept(is_d, 1'b0, addr, ok);
      if (!ok) return;
      for (int n = 1; n <= 40 && last_at < 0; n++) begin
         @(negedge clk); #1;
         if (is_d ? d_rsp_vld : i_rsp_vld) begin
            if (lat < 0) lat = n;
            if (nbeats < 16) words[nbeats] = is_d ? d_rsp_data : i_rsp_data;
            if (is_d ? d_rsp_last : i_rsp_last) last_at = nbeats;
            nbeats++;
         end else if ((is_d ? d_rsp_data : i_rsp_data) != 0 || (is_d ? d_rsp_last : i_rsp_last)) begin
            stray = 1'b1;
         end
         if (is_d ? i_rsp_vld : d_rsp_vld) stray = 1'b1;
      end
   endtask

   // Beat k lands on cycle k+1 (contiguous) or 2k+2 (gapped); other cycles carry junk.
   task automatic run_write(input logic [31:0] addr, input logic [31:0] base, input bit gap,
                            output bit ok, output int done_at, output int done_cnt,
                            output int err_at, output int err_cnt);
      int last_t;
      last_t = gap ? 32 : 16;
      done_at = -1; done_cnt = 0; err_at = -1; err_cnt = 0;
      req_accept(1'b1, 1'b1, addr, ok);
      for (int t = 1; t <= last_t + 4; t++) begin
         @(negedge clk);
         if (t <= last_t && (!gap || (t % 2) == 0)) begin
            d_wvld = 1'b1;
            d_wdata = base + 32'(gap ? (t / 2 - 1) : (t - 1));
         end else begin
            d_wvld = (t > last_t);
            d_wdata = 32'hDEAD_0000 + 32'(t);
         end
         #1;
         if (d_wr_done) begin done_cnt++; if (done_at < 0) done_at = t; end
         if (d_rsp_err) begin err_cnt++; if (err_at < 0) err_at = t; end
      end
      @(negedge clk);
      d_wvld = 1'b0; d_wdata = '0;
   endtask

   task automatic test_reset();
      i_req_vld = 1'b1; d_req_vld = 1'b1; i_req_addr = 32'h40; d_req_addr = 32'h80;
      #1;
      checks++;
      if (all_outs() !== 73'h0)
         $display("FAIL reset_outputs got %h expected 0", all_outs());
      if (all_outs() !== 73'h0) errors++;
      @(negedge clk); i_req_vld = 1'b0; d_req_vld = 1'b0;
      @(posedge clk); #1; rst = 1'b0;
   endtask

   task automatic test_write_read();
      bit ok, stray; int done_at, done_cnt, err_at, err_cnt, lat, nb, last_at;
      logic [31:0] w [16];
      run_write(32'h0000_0000, 32'h1000, 1'b0, ok, done_at, done_cnt, err_at, err_cnt);
      checks++;
      if (!ok || done_at != 17) begin errors++; $display("FAIL wr_line0_done got %0d expected 17", done_at); end
      run_write(32'h0000_0040, 32'hA0, 1'b0, ok, done_at, done_cnt, err_at, err_cnt);
      checks++;
      if (!ok || done_at != 17 || done_cnt != 1) begin
         errors++; $display("FAIL wr_line1_done got at %0d cnt %0d expected at 17 cnt 1", done_at, done_cnt);
      end
      run_fill(1'b0, 32'h0000_0044, ok, lat, nb, w, last_at, stray);
      checks++;
      if (!ok || lat != 4) begin errors++; $display("FAIL rd_line1_latency got %0d expected 4", lat); end
      checks++;
      if (nb != 16 || last_at != 15 || stray) begin
         errors++; $display("FAIL rd_line1_framing got beats %0d last %0d stray %0b expected 16 15 0", nb, last_at, stray);
      end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (w[k] !== 32'hA0 + 32'(k)) begin
            errors++; $display("FAIL rd_line1_word%0d got %h expected %h", k, w[k], 32'hA0 + 32'(k));
         end
      end
   endtask

   task automatic test_stall_write();
      bit ok, stray; int done_at, done_cnt, err_at, err_cnt, lat, nb, last_at;
      logic [31:0] w [16];
      run_write(32'h0000_0080, 32'hB0, 1'b1, ok, done_at, done_cnt, err_at, err_cnt);
      checks++;
      if (!ok || done_at != 33 || done_cnt != 1) begin
         errors++; $display("FAIL stall_done got at %0d cnt %0d expected at 33 cnt 1", done_at, done_cnt);
      end
      run_fill(1'b1, 32'h0000_0080, ok, lat, nb, w, last_at, stray);
      checks++;
      if (!ok || lat != 4 || nb != 16 || last_at != 15 || stray) begin
         errors++; $display("FAIL stall_readback_framing got lat %0d beats %0d last %0d expected 4 16 15", lat, nb, last_at);
      end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (w[k] !== 32'hB0 + 32'(k)) begin
            errors++; $display("FAIL stall_word%0d got %h expected %h", k, w[k], 32'hB0 + 32'(k));
         end
      end
   endtask

   task automatic test_out_of_range();
      bit ok, stray; int done_at, done_cnt, err_at, err_cnt, lat, nb, last_at;
      logic [31:0] w [16];
      run_write(32'h0000_4000, 32'hEE00, 1'b0, ok, done_at, done_cnt, err_at, err_cnt);
      checks++;
      if (!ok || err_at != 1 || err_cnt != 1) begin
         errors++; $display("FAIL oor_err got at %0d cnt %0d expected at 1 cnt 1", err_at, err_cnt);
      end
      checks++;
      if (done_cnt != 0) begin errors++; $display("FAIL oor_no_done got %0d expected 0", done_cnt); end
      run_fill(1'b1, 32'h0000_0000, ok, lat, nb, w, last_at, stray);
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (w[k] !== 32'h1000 + 32'(k)) begin
            errors++; $display("FAIL oor_line0_word%0d got %h expected %h", k, w[k], 32'h1000 + 32'(k));
         end
      end
      run_write(32'h0000_3FC0, 32'h5500, 1'b0, ok, done_at, done_cnt, err_at, err_cnt);
      checks++;
      if (!ok || done_at != 17 || err_cnt != 0) begin
         errors++; $display("FAIL line255_write got done %0d err %0d expected 17 0", done_at, err_cnt);
      end
      run_fill(1'b0, 32'h0000_3FC4, ok, lat, nb, w, last_at, stray);
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (w[k] !== 32'h5500 + 32'(k)) begin
            errors++; $display("FAIL line255_word%0d got %h expected %h", k, w[k], 32'h5500 + 32'(k));
         end
      end
   endtask

   task automatic test_simultaneous();
      int i_rdy_at, d_first_at, d_last_at;
      logic [31:0] d_w0;
      @(negedge clk); rst = 1'b1; #1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      i_req_vld = 1'b1; i_req_addr = 32'h44;
      d_req_vld = 1'b1; d_req_wr = 1'b0; d_req_addr = 32'h80;
      #1;
      checks++;
      if (d_req_rdy !== 1'b1 || i_req_rdy !== 1'b0) begin
         errors++; $display("FAIL tie_first_grant got d %b i %b expected d 1 i 0", d_req_rdy, i_req_rdy);
      end
      @(posedge clk); #1; d_req_vld = 1'b0;
      i_rdy_at = -1; d_first_at = -1; d_last_at = -1; d_w0 = '0;
      for (int t = 1; t <= 40 && i_rdy_at < 0; t++) begin
         @(negedge clk); #1;
         if (d_rsp_vld && d_first_at < 0) begin d_first_at = t; d_w0 = d_rsp_data; end
         if (d_rsp_last) d_last_at = t;
         if (i_req_rdy) i_rdy_at = t;
      end
      checks++;
      if (d_first_at != 4 || d_w0 !== 32'hB0 || d_last_at != 19) begin
         errors++; $display("FAIL tie_d_burst got first %0d w0 %h last %0d expected 4 b0 19", d_first_at, d_w0, d_last_at);
      end
      checks++;
      if (i_rdy_at != 20) begin errors++; $display("FAIL tie_i_grant got %0d expected 20", i_rdy_at); end
      @(posedge clk); #1; i_req_vld = 1'b0;
      for (int t = 1; t <= 19; t++) @(negedge clk);
      @(negedge clk);
      i_req_vld = 1'b1; d_req_vld = 1'b1; d_req_wr = 1'b0;
      #1;
      checks++;
      if (d_req_rdy !== 1'b1 || i_req_rdy !== 1'b0) begin
         errors++; $display("FAIL tie_alternation got d %b i %b expected d 1 i 0", d_req_rdy, i_req_rdy);
      end
      @(posedge clk); #1; d_req_vld = 1'b0;
      i_rdy_at = -1;
      for (int t = 1; t <= 40 && i_rdy_at < 0; t++) begin
         @(negedge clk); #1;
         if (i_req_rdy) i_rdy_at = t;
      end
      checks++;
      if (i_rdy_at != 20) begin errors++; $display("FAIL tie_i_second_grant got %0d expected 20", i_rdy_at); end
      @(posedge clk); #1; i_req_vld = 1'b0;
      for (int t = 1; t <= 22; t++) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit ok, stray, seen; int lat, nb, last_at;
      logic [31:0] w [16];
      req_accept(1'b0, 1'b0, 32'h0000_0040, ok);
      for (int t = 1; t <= 11; t++) begin @(negedge clk); #1; end
      checks++;
      if (i_rsp_vld !== 1'b1 || i_rsp_data !== 32'hA7) begin
         errors++; $display("FAIL mid_beat7 got vld %b data %h expected 1 a7", i_rsp_vld, i_rsp_data);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (all_outs() !== 73'h0) begin errors++; $display("FAIL mid_reset_outputs got %h expected 0", all_outs()); end
      @(posedge clk); #1; rst = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 25; t++) begin
         @(negedge clk); #1;
         if (i_rsp_vld || i_rsp_last || i_rsp_err || d_wr_done) seen = 1'b1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL mid_no_tail got activity 1 expected 0"); end
      run_fill(1'b0, 32'h0000_0048, ok, lat, nb, w, last_at, stray);
      checks++;
      if (!ok || lat != 4 || nb != 16 || last_at != 15 || w[0] !== 32'hA0 || w[15] !== 32'hAF) begin
         errors++; $display("FAIL mid_refill got lat %0d beats %0d w0 %h w15 %h expected 4 16 a0 af", lat, nb, w[0], w[15]);
      end
   endtask

   task automatic test_busy_hold();
      bit ok; int rdy_at, first_at, nb;
      logic [31:0] w [16];
      req_accept(1'b0, 1'b0, 32'h0000_0040, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL busy_i_accept got 0 expected 1"); end
      rdy_at = -1;
      for (int t = 1; t <= 40 && rdy_at < 0; t++) begin
         @(negedge clk);
         if (t == 2) begin d_req_vld = 1'b1; d_req_wr = 1'b0; d_req_addr = 32'h0000_0088; end
         #1;
         if (d_req_rdy) rdy_at = t;
      end
      checks++;
      if (rdy_at != 20) begin errors++; $display("FAIL busy_d_rdy got %0d expected 20", rdy_at); end
      @(posedge clk); #1; d_req_vld = 1'b0; d_req_addr = 32'h0;
      first_at = -1; nb = 0;
      for (int k = 0; k < 16; k++) w[k] = '0;
      for (int t = 1; t <= 25; t++) begin
         @(negedge clk); #1;
         if (d_rsp_vld) begin
            if (first_at < 0) first_at = t;
            if (nb < 16) w[nb] = d_rsp_data;
            nb++;
         end
      end
      checks++;
      if (first_at != 4 || nb != 16) begin
         errors++; $display("FAIL busy_d_burst got first %0d beats %0d expected 4 16", first_at, nb);
      end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (w[k] !== 32'hB0 + 32'(k)) begin
            errors++; $display("FAIL busy_word%0d got %h expected %h", k, w[k], 32'hB0 + 32'(k));
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_stall_write();
      test_out_of_range();
      test_simultaneous();
      test_reset_mid();
      test_busy_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

endmodule
